audio_sample_conditioner: RTL and testbench

AUDIO_SAMPLE_CONDITIONER -- requirements
Module: audio_sample_conditioner

---
 rtl/audio_sample_conditioner.sv | 139 +++++++++++++
 tb/tb_audio_sample_conditioner.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : audio_sample_conditioner
// Brief    : Converts ADC codes to signed audio. Detects sample-valid edges,
//            averages blocks of 2^AVG_LOG2 samples, optionally removes DC with
//            a leaky integrator, and applies gain with saturation.
// Revision : 1.0 - initial release
// ============================================================================
module audio_sample_conditioner #(
   parameter int AVG_LOG2 = 2,
   parameter int DC_SHIFT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        sample_valid,
   input  logic [11:0] sample_in,
   input  logic        dc_en,
   input  logic [1:0]  gain,
   output logic [15:0] sample_out,
   output logic        sample_out_valid,
   output logic        clip
);

   localparam int ACC_W = 13 + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int DC_W  = 14 + DC_SHIFT;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   logic                    r_sv_prev;
   logic signed [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0]        r_cnt;
   logic signed [12:0]      r_avg;
   logic                    r_v1;
   logic signed [14:0]      r_hp;
   logic                    r_v2;
   logic signed [DC_W-1:0]  r_dc_acc;

   logic                    w_capture;
   logic signed [12:0]      w_s;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [14:0]      w_hp;
   logic [2:0]              w_shamt;
   logic signed [21:0]      w_y;
   logic                    w_sat_hi;
   logic                    w_sat_lo;

   // A sample is taken only on the rising edge of the valid level.
   assign w_capture = enable & sample_valid & ~r_sv_prev;
   // Offset-binary ADC code to two's complement around mid-scale.
   assign w_s       = $signed({1'b0, sample_in}) - 13'sd2048;
   assign w_sum     = r_acc + ACC_W'(w_s);
   // DC estimate is the integrator scaled down by its time constant.
   assign w_hp      = dc_en ? (15'(r_avg) - 15'(r_dc_acc >>> DC_SHIFT)) : 15'(r_avg);
   assign w_shamt   = {1'b0, gain} + 3'd4;
   assign w_y       = 22'(r_hp) <<< w_shamt;
   assign w_sat_hi  = (w_y > 22'sd32767);
   assign w_sat_lo  = (w_y < -22'sd32768);

   // Edge history follows sample_valid in every cycle, including reset and
   // disable, so a level already high before the block is running never
   // counts as a fresh edge.
   always_ff @(posedge clk) begin
      r_sv_prev <= sample_valid;
   end

   // Stage 1: block accumulation and averaging by arithmetic shift.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_avg <= '0;
         r_v1  <= 1'b0;
      end else if (!enable) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_v1  <= 1'b0;
      end else begin
         r_v1 <= 1'b0;
         if (w_capture) begin
            if (r_cnt == CNT_LAST) begin
               r_avg <= 13'(w_sum >>> AVG_LOG2);
               r_acc <= '0;
               r_cnt <= '0;
               r_v1  <= 1'b1;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Stage 2: DC removal; the integrator is parked at zero while bypassed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hp     <= '0;
         r_v2     <= 1'b0;
         r_dc_acc <= '0;
      end else if (!enable) begin
         r_v2 <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_hp <= w_hp;
         end
         if (!dc_en) begin
            r_dc_acc <= '0;
         end else if (r_v1) begin
            r_dc_acc <= r_dc_acc + DC_W'(w_hp);
         end
      end
   end

   // Stage 3: gain, saturation and the single-cycle output strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_out       <= 16'h0000;
         sample_out_valid <= 1'b0;
         clip             <= 1'b0;
      end else begin
         sample_out_valid <= 1'b0;
         clip             <= 1'b0;
         if (enable && r_v2) begin
            sample_out_valid <= 1'b1;
            clip             <= w_sat_hi | w_sat_lo;
            if (w_sat_hi) begin
               sample_out <= 16'h7FFF;
            end else if (w_sat_lo) begin
               sample_out <= 16'h8000;
            end else begin
               sample_out <= w_y[15:0];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_audio_sample_conditioner
// Brief    : Self-checking bench. Instance A uses the default averaging of
//            four samples; instance B averages single samples so blocks can
//            arrive back to back and long DC runs stay short.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_sample_conditioner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        a_enable, a_sv, a_dc_en, a_valid, a_clip;
   logic [11:0] a_in;
   logic [1:0]  a_gain;
   logic [15:0] a_out;
   logic        b_enable, b_sv, b_dc_en, b_valid, b_clip;
   logic [11:0] b_in;
   logic [1:0]  b_gain;
   logic [15:0] b_out;

   int checks   = 0;
   int failures = 0;

   // Observed outputs as {clip, sample_out}.
   logic [16:0] a_q[$];
   logic [16:0] b_q[$];

   audio_sample_conditioner #(.AVG_LOG2(2), .DC_SHIFT(10)) u_dut_a (
      .clk(clk), .reset(reset), .enable(a_enable), .sample_valid(a_sv),
      .sample_in(a_in), .dc_en(a_dc_en), .gain(a_gain), .sample_out(a_out),
      .sample_out_valid(a_valid), .clip(a_clip)
   );

   audio_sample_conditioner #(.AVG_LOG2(0), .DC_SHIFT(10)) u_dut_b (
      .clk(clk), .reset(reset), .enable(b_enable), .sample_valid(b_sv),
      .sample_in(b_in), .dc_en(b_dc_en), .gain(b_gain), .sample_out(b_out),
      .sample_out_valid(b_valid), .clip(b_clip)
   );

   always @(negedge clk) begin
      if (a_valid === 1'b1) a_q.push_back({a_clip, a_out});
      if (b_valid === 1'b1) b_q.push_back({b_clip, b_out});
   end

   // ---------------- reference model helpers ----------------
   function automatic int floor_div(input int n, input int d);
      int q;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      return q;
   endfunction

   function automatic logic [16:0] shape(input int hp, input int g);
      int          y;
      logic [31:0] yb;
      y = hp * (16 << g);
      if (y > 32767)  return {1'b1, 16'h7FFF};
      if (y < -32768) return {1'b1, 16'h8000};
      yb = 32'(y);
      return {1'b0, yb[15:0]};
   endfunction

   // ---------------- stimulus helpers (tasks start 1 ns after posedge) ----
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic a_send(input logic [11:0] x);
      a_sv = 1'b1; a_in = x; tick(1);
      a_sv = 1'b0;           tick(1);
   endtask

   task automatic b_send(input logic [11:0] x);
      b_sv = 1'b1; b_in = x; tick(1);
      b_sv = 1'b0;           tick(1);
   endtask

   task automatic a_block(input logic [11:0] x, input logic [1:0] g);
      a_gain = g;
      for (int i = 0; i < 4; i++) a_send(x);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      tick(3);
      @(negedge clk);
      checks++; if (a_out !== 16'h0000) begin failures++; $display("FAIL reset_out: got %h expected 0000", a_out); end
      checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
      checks++; if (a_clip !== 1'b0) begin failures++; $display("FAIL reset_clip: got %b expected 0", a_clip); end
      checks++; if (b_out !== 16'h0000 || b_valid !== 1'b0) begin failures++; $display("FAIL reset_b: got out=%h valid=%b expected 0000/0", b_out, b_valid); end
      @(posedge clk); #1;
      reset = 1'b0; a_enable = 1'b1;
      tick(4);
      checks++; if (a_q.size() != 0) begin failures++; $display("FAIL reset_idle: got %0d outputs expected 0", a_q.size()); end
   endtask

   task automatic test_basic();
      a_q.delete(); a_dc_en = 1'b0; a_gain = 2'd0;
      for (int i = 0; i < 3; i++) a_send(12'hC00);
      a_sv = 1'b1; a_in = 12'hC00; tick(1);   // cycle T captured here
      a_sv = 1'b0;                 tick(1);   // now in cycle T+2
      @(negedge clk);
      checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL basic_early: got valid=%b at T+2 expected 0", a_valid); end
      @(negedge clk);
      checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got valid=%b at T+3 expected 1", a_valid); end
      checks++; if (a_out !== 16'h4000) begin failures++; $display("FAIL basic_out: got %h expected 4000", a_out); end
      checks++; if (a_clip !== 1'b0) begin failures++; $display("FAIL basic_clip: got %b expected 0", a_clip); end
      @(negedge clk);
      checks++; if (a_valid !== 1'b0 || a_out !== 16'h4000) begin failures++; $display("FAIL basic_pulse: got valid=%b out=%h expected 0/4000", a_valid, a_out); end
      @(posedge clk); #1;
   endtask

   task automatic test_saturation();
      logic [11:0] xs [3];
      logic [1:0]  gs [3];
      logic [16:0] ex [3];
      logic [16:0] got;
      xs[0] = 12'hC00; gs[0] = 2'd3; ex[0] = {1'b1, 16'h7FFF};
      xs[1] = 12'h000; gs[1] = 2'd0; ex[1] = {1'b0, 16'h8000};
      xs[2] = 12'h000; gs[2] = 2'd1; ex[2] = {1'b1, 16'h8000};
      for (int k = 0; k < 3; k++) begin
         a_q.delete();
         a_block(xs[k], gs[k]);
         tick(6);
         checks++;
         if (a_q.size() != 1) begin
            failures++; $display("FAIL sat_count%0d: got %0d outputs expected 1", k, a_q.size());
         end else begin
            got = a_q.pop_front();
            checks++; if (got[15:0] !== ex[k][15:0]) begin failures++; $display("FAIL sat_out%0d: got %h expected %h", k, got[15:0], ex[k][15:0]); end
            checks++; if (got[16] !== ex[k][16]) begin failures++; $display("FAIL sat_clip%0d: got %b expected %b", k, got[16], ex[k][16]); end
         end
      end
      a_gain = 2'd0;
   endtask

   task automatic test_held_level();
      a_q.delete();
      a_sv = 1'b1; a_in = 12'hC00; tick(10);
      a_sv = 1'b0; tick(1);
      for (int i = 0; i < 3; i++) a_send(12'hC00);
      tick(8);
      checks++;
      if (a_q.size() != 1) begin
         failures++; $display("FAIL held_count: got %0d outputs expected 1", a_q.size());
      end else begin
         checks++; if (a_q[0] !== {1'b0, 16'h4000}) begin failures++; $display("FAIL held_out: got %h expected 04000", a_q[0]); end
      end
   endtask

   task automatic test_reset_mid_block();
      a_q.delete();
      a_send(12'h000); a_send(12'h000);
      reset = 1'b1; tick(2);
      reset = 1'b0; tick(6);
      checks++; if (a_q.size() != 0) begin failures++; $display("FAIL rstmid_none: got %0d outputs expected 0", a_q.size()); end
      for (int i = 0; i < 4; i++) a_send(12'hC00);
      tick(8);
      checks++;
      if (a_q.size() != 1) begin
         failures++; $display("FAIL rstmid_count: got %0d outputs expected 1", a_q.size());
      end else begin
         checks++; if (a_q[0] !== {1'b0, 16'h4000}) begin failures++; $display("FAIL rstmid_out: got %h expected 04000", a_q[0]); end
      end
   endtask

   task automatic test_enable_drop();
      a_q.delete();
      for (int i = 0; i < 3; i++) a_send(12'hC00);
      a_sv = 1'b1; a_in = 12'hC00; tick(1);   // cycle T captured here
      a_sv = 1'b0; a_enable = 1'b0; tick(1);
      tick(2);
      a_send(12'h000); a_send(12'h000);       // edges while disabled are ignored
      a_enable = 1'b1; tick(6);
      checks++; if (a_q.size() != 0) begin failures++; $display("FAIL endrop_none: got %0d outputs expected 0", a_q.size()); end
      for (int i = 0; i < 4; i++) a_send(12'hC00);
      tick(8);
      checks++;
      if (a_q.size() != 1) begin
         failures++; $display("FAIL endrop_count: got %0d outputs expected 1", a_q.size());
      end else begin
         checks++; if (a_q[0] !== {1'b0, 16'h4000}) begin failures++; $display("FAIL endrop_out: got %h expected 04000", a_q[0]); end
      end
   endtask

   task automatic test_random_blocks();
      logic [16:0] exp_q[$];
      logic [11:0] x;
      int          sum, avg, hp, g, dce;
      int          dc = 0;
      int          nblk = 40;
      a_q.delete();
      for (int b = 0; b < nblk; b++) begin
         g = int'($urandom_range(0, 3));
         dce = int'($urandom_range(0, 1));
         a_gain = 2'(g); a_dc_en = 1'(dce);
         sum = 0;
         for (int i = 0; i < 4; i++) begin
            x = 12'($urandom_range(0, 4095));
            sum += int'(x) - 2048;
            a_send(x);
         end
         avg = floor_div(sum, 4);
         if (dce != 0) begin
            hp = avg - floor_div(dc, 1024);
            dc = dc + hp;
         end else begin
            hp = avg;
            dc = 0;
         end
         exp_q.push_back(shape(hp, g));
         tick(5);
      end
      checks++;
      if (a_q.size() != nblk) begin
         failures++; $display("FAIL rand_count: got %0d outputs expected %0d", a_q.size(), nblk);
      end else begin
         for (int b = 0; b < nblk; b++) begin
            checks++;
            if (a_q[b] !== exp_q[b]) begin failures++; $display("FAIL rand_blk%0d: got %h expected %h", b, a_q[b], exp_q[b]); end
         end
      end
      a_dc_en = 1'b0; a_gain = 2'd0;
   endtask

   task automatic test_back_to_back();
      logic [16:0] exp_q[$];
      logic [11:0] x;
      int          g;
      int          n = 64;
      b_q.delete();
      g = int'($urandom_range(0, 3));
      b_gain = 2'(g); b_dc_en = 1'b0; b_enable = 1'b1;
      for (int i = 0; i < n; i++) begin
         x = 12'($urandom_range(0, 4095));
         exp_q.push_back(shape(int'(x) - 2048, g));
         b_send(x);
      end
      tick(8);
      checks++;
      if (b_q.size() != n) begin
         failures++; $display("FAIL b2b_count: got %0d outputs expected %0d", b_q.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (b_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_%0d: got %h expected %h", i, b_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_dc_tracking();
      logic [16:0] exp_q[$];
      logic [16:0] got;
      int          dc = 0;
      int          hp, mag;
      int          prev_mag = 32768;
      int          bad_model = 0;
      int          bad_mono = 0;
      int          first_bad = -1;
      int          nblk = 16384;
      b_q.delete();
      b_gain = 2'd0; b_dc_en = 1'b1; b_enable = 1'b1;
      for (int i = 0; i < nblk; i++) begin
         hp = 1024 - floor_div(dc, 1024);
         dc = dc + hp;
         exp_q.push_back(shape(hp, 0));
         b_send(12'hC00);
      end
      tick(8);
      checks++;
      if (b_q.size() != nblk) begin
         failures++; $display("FAIL dc_count: got %0d outputs expected %0d", b_q.size(), nblk);
      end else begin
         checks++; if (b_q[0] !== {1'b0, 16'h4000}) begin failures++; $display("FAIL dc_first: got %h expected 04000", b_q[0]); end
         for (int i = 0; i < nblk; i++) begin
            got = b_q[i];
            if (got !== exp_q[i]) begin
               bad_model++;
               if (first_bad < 0) first_bad = i;
            end
            mag = int'($signed(got[15:0]));
            if (mag < 0) mag = -mag;
            if (mag > prev_mag) bad_mono++;
            prev_mag = mag;
         end
         checks++; if (bad_model != 0) begin failures++; $display("FAIL dc_model: got %0d mismatching outputs (first at %0d) expected 0", bad_model, first_bad); end
         checks++; if (bad_mono != 0) begin failures++; $display("FAIL dc_monotonic: got %0d magnitude increases expected 0", bad_mono); end
         checks++; if (prev_mag > 16) begin failures++; $display("FAIL dc_final: got |out|=%0d expected <=16", prev_mag); end
      end
   endtask

   initial begin
      reset = 1'b1;
      a_enable = 1'b0; a_sv = 1'b0; a_in = 12'h000; a_dc_en = 1'b0; a_gain = 2'd0;
      b_enable = 1'b0; b_sv = 1'b0; b_in = 12'h000; b_dc_en = 1'b0; b_gain = 2'd0;
      #1;
      test_reset();
      test_basic();
      test_saturation();
      test_held_level();
      test_reset_mid_block();
      test_enable_drop();
      test_random_blocks();
      test_back_to_back();
      test_dc_tracking();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
